// File: rtl/subleq_pipe.sv
// Two-stage SUBLEQ datapath: signed reg_2 - reg_1 with branch condition, overflow and a saturating branch counter.
// Latency: 2 cycles from input transfer to out_valid, 1 result per cycle.
// Backpressure: a stage advances when empty or when its successor advances; in_ready does not depend on in_valid.
module subleq_pipe #(
    parameter int WIDTH     = 8,
    parameter int SATURATE  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     reg_1,
    input  logic [WIDTH-1:0]     reg_2,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 branch,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] branch_count
);

    typedef enum logic [1:0] {
        MODE_LEQ    = 2'd0,
        MODE_LT     = 2'd1,
        MODE_EQ     = 2'd2,
        MODE_ALWAYS = 2'd3
    } mode_e;

    typedef struct packed {
        logic [WIDTH:0] diff;
        mode_e          mode;
    } s1_t;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic           s1_valid;
    s1_t            s1_q;
    logic           s2_valid;
    logic           s1_adv;
    logic           s2_adv;
    logic           out_fire;
    logic [WIDTH:0] diff_c;

    logic             neg_c;
    logic             zero_c;
    logic             ovf_c;
    logic             br_c;
    logic [WIDTH-1:0] res_c;

    assign out_fire  = s2_valid && out_ready;
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // One extra bit keeps the true difference of two WIDTH-bit signed values exact.
    assign diff_c = {reg_2[WIDTH-1], reg_2} - {reg_1[WIDTH-1], reg_1};

    always_comb begin
        neg_c  = s1_q.diff[WIDTH];
        zero_c = (s1_q.diff == '0);
        ovf_c  = s1_q.diff[WIDTH] ^ s1_q.diff[WIDTH-1];
        res_c  = s1_q.diff[WIDTH-1:0];
        br_c   = 1'b0;
        if ((SATURATE != 0) && ovf_c) begin
            res_c = neg_c ? SMIN : SMAX;
        end
        case (s1_q.mode)
            MODE_LEQ:    br_c = neg_c || zero_c;
            MODE_LT:     br_c = neg_c;
            MODE_EQ:     br_c = zero_c;
            MODE_ALWAYS: br_c = 1'b1;
            default:     br_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q.diff <= diff_c;
                s1_q.mode <= mode_e'(mode);
            end
        end
    end

    // Output registers only reload from a valid stage 1, so a stalled result stays put.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s2_valid <= 1'b0;
            result   <= '0;
            branch   <= 1'b0;
            overflow <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result   <= res_c;
                branch   <= br_c;
                overflow <= ovf_c;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            branch_count <= '0;
        end else if (out_fire && branch && (branch_count != {CNT_WIDTH{1'b1}})) begin
            branch_count <= branch_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule
